// File: rtl/branch_ctrl_pkg.sv
// Shared definitions for the branch/jump sequencer: opcodes, mux encodings
// and the FSM state type.
package branch_ctrl_pkg;

  localparam logic [5:0] OPC_J   = 6'h02;
  localparam logic [5:0] OPC_JAL = 6'h03;
  localparam logic [5:0] OPC_BEQ = 6'h04;
  localparam logic [5:0] OPC_BNE = 6'h05;
  localparam logic [5:0] OPC_BLE = 6'h06;
  localparam logic [5:0] OPC_BGT = 6'h07;

  localparam logic [1:0] PCS_ALU    = 2'd0;
  localparam logic [1:0] PCS_ALUOUT = 2'd1;
  localparam logic [1:0] PCS_JUMP   = 2'd2;

  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_RT   = 2'd2;
  localparam logic [1:0] SRCB_OFFS = 2'd3;

  localparam logic [1:0] ALUOP_ADD = 2'd0;
  localparam logic [1:0] ALUOP_SUB = 2'd1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TARGET  = 3'd1,
    ST_COMPARE = 3'd2,
    ST_LINK    = 3'd3,
    ST_JUMP    = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

endpackage

// File: rtl/branch_ctrl_if.sv
// Handshake, ALU flag and control-output bundle between the main control
// unit (master) and the branch sequencer (slave).
interface branch_ctrl_if #(
  parameter int OPC_W = 6
);
  logic             start;
  logic [OPC_W-1:0] opcode;
  logic             Zero;
  logic             Gt;
  logic             busy;
  logic             done;
  logic             err;
  logic             PCWrite;
  logic             PCWriteCond;
  logic             EQorNE;
  logic             GTorLT;
  logic             CmpEqEn;
  logic             CmpGtEn;
  logic [1:0]       PCSource;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic             ALUOutWrite;
  logic             LinkWrite;

  modport master (
    output start, opcode, Zero, Gt,
    input  busy, done, err, PCWrite, PCWriteCond, EQorNE, GTorLT,
           CmpEqEn, CmpGtEn, PCSource, ALUSrcA, ALUSrcB, ALUOp,
           ALUOutWrite, LinkWrite
  );

  modport slave (
    input  start, opcode, Zero, Gt,
    output busy, done, err, PCWrite, PCWriteCond, EQorNE, GTorLT,
           CmpEqEn, CmpGtEn, PCSource, ALUSrcA, ALUSrcB, ALUOp,
           ALUOutWrite, LinkWrite
  );
endinterface

// File: rtl/branch_stat_cnt.sv
// Saturating event counter: holds at all-ones instead of wrapping.
module branch_stat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Count one event per asserted inc, sticking at the maximum.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt <= '0;
    else if (inc) cnt <= sat_inc(cnt);
  end

endmodule

// File: rtl/branch_ctrl.sv
// Branch/jump sub-FSM. Sequences TARGET/COMPARE for conditional branches and
// LINK/JUMP for jal/j, with registered Moore outputs. Optional taken/not-taken
// statistics are built when BRANCH_CTRL_STATS_EN is defined.
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int OPC_W = 6,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  branch_ctrl_if.slave     bus
`ifdef BRANCH_CTRL_STATS_EN
  ,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] nottaken_cnt
`endif
);

  state_e           state;
  logic [OPC_W-1:0] opc_r;

  // Capture the opcode at accept so later input changes do not matter.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && bus.start) opc_r <= bus.opcode;
  end

  // State register plus outputs registered for the state being entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.err         <= 1'b0;
      bus.PCWrite     <= 1'b0;
      bus.PCWriteCond <= 1'b0;
      bus.EQorNE      <= 1'b0;
      bus.GTorLT      <= 1'b0;
      bus.CmpEqEn     <= 1'b0;
      bus.CmpGtEn     <= 1'b0;
      bus.PCSource    <= PCS_ALU;
      bus.ALUSrcA     <= 1'b0;
      bus.ALUSrcB     <= 2'd0;
      bus.ALUOp       <= ALUOP_ADD;
      bus.ALUOutWrite <= 1'b0;
      bus.LinkWrite   <= 1'b0;
    end else begin
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.err         <= 1'b0;
      bus.PCWrite     <= 1'b0;
      bus.PCWriteCond <= 1'b0;
      bus.EQorNE      <= 1'b0;
      bus.GTorLT      <= 1'b0;
      bus.CmpEqEn     <= 1'b0;
      bus.CmpGtEn     <= 1'b0;
      bus.PCSource    <= PCS_ALU;
      bus.ALUSrcA     <= 1'b0;
      bus.ALUSrcB     <= 2'd0;
      bus.ALUOp       <= ALUOP_ADD;
      bus.ALUOutWrite <= 1'b0;
      bus.LinkWrite   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            case (bus.opcode)
              OPC_BEQ, OPC_BNE, OPC_BLE, OPC_BGT: begin
                state           <= ST_TARGET;
                bus.busy        <= 1'b1;
                bus.ALUSrcB     <= SRCB_OFFS;
                bus.ALUOp       <= ALUOP_ADD;
                bus.ALUOutWrite <= 1'b1;
              end
              OPC_JAL: begin
                state         <= ST_LINK;
                bus.busy      <= 1'b1;
                bus.LinkWrite <= 1'b1;
              end
              OPC_J: begin
                state        <= ST_JUMP;
                bus.busy     <= 1'b1;
                bus.PCWrite  <= 1'b1;
                bus.PCSource <= PCS_JUMP;
              end
              default: begin
                state    <= ST_DONE;
                bus.done <= 1'b1;
                bus.err  <= 1'b1;
              end
            endcase
          end
        end
        ST_TARGET: begin
          state           <= ST_COMPARE;
          bus.busy        <= 1'b1;
          bus.ALUSrcA     <= 1'b1;
          bus.ALUSrcB     <= SRCB_RT;
          bus.ALUOp       <= ALUOP_SUB;
          bus.PCWriteCond <= 1'b1;
          bus.PCSource    <= PCS_ALUOUT;
          case (opc_r)
            OPC_BEQ: bus.CmpEqEn <= 1'b1;
            OPC_BNE: begin
              bus.CmpEqEn <= 1'b1;
              bus.EQorNE  <= 1'b1;
            end
            OPC_BGT: bus.CmpGtEn <= 1'b1;
            OPC_BLE: begin
              // Taken on Zero or ~Gt: both terms feed the downstream OR.
              bus.CmpEqEn <= 1'b1;
              bus.CmpGtEn <= 1'b1;
              bus.GTorLT  <= 1'b1;
            end
            default: ;
          endcase
        end
        ST_COMPARE: begin
          state    <= ST_DONE;
          bus.done <= 1'b1;
        end
        ST_LINK: begin
          state        <= ST_JUMP;
          bus.busy     <= 1'b1;
          bus.PCWrite  <= 1'b1;
          bus.PCSource <= PCS_JUMP;
        end
        ST_JUMP: begin
          state    <= ST_DONE;
          bus.done <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef BRANCH_CTRL_STATS_EN
  logic cond_true;
  logic in_cmp;

  assign cond_true = (bus.CmpEqEn & (bus.Zero ^ bus.EQorNE)) |
                     (bus.CmpGtEn & (bus.Gt ^ bus.GTorLT));
  assign in_cmp    = (state == ST_COMPARE);

  branch_stat_cnt #(.CNT_W(CNT_W)) u_taken_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (in_cmp & cond_true),
    .cnt     (taken_cnt)
  );

  branch_stat_cnt #(.CNT_W(CNT_W)) u_nottaken_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (in_cmp & ~cond_true),
    .cnt     (nottaken_cnt)
  );
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl: the driver pushes the expected per-cycle
// output sequence of each accepted instruction; a monitor pops and compares.
module tb_branch_ctrl;

  typedef struct packed {
    logic       busy, done, err, pcw, pcwc, eqne, gtlt, ceq, cgt;
    logic [1:0] pcsrc;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] aluop;
    logic       aow, lw;
  } ovec_t;

  typedef struct packed {
    ovec_t v;
    logic  chk;
    logic  taken;
  } rec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  branch_ctrl_if #(.OPC_W(6)) bi ();

`ifdef BRANCH_CTRL_STATS_EN
  logic [15:0] taken_cnt, nottaken_cnt;
`endif

  branch_ctrl #(.OPC_W(6), .CNT_W(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bi)
`ifdef BRANCH_CTRL_STATS_EN
    ,
    .taken_cnt    (taken_cnt),
    .nottaken_cnt (nottaken_cnt)
`endif
  );

  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  rec_t q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ovec_t dut_vec();
    ovec_t v;
    v.busy  = bi.busy;        v.done = bi.done;       v.err  = bi.err;
    v.pcw   = bi.PCWrite;     v.pcwc = bi.PCWriteCond;
    v.eqne  = bi.EQorNE;      v.gtlt = bi.GTorLT;
    v.ceq   = bi.CmpEqEn;     v.cgt  = bi.CmpGtEn;
    v.pcsrc = bi.PCSource;    v.srca = bi.ALUSrcA;    v.srcb = bi.ALUSrcB;
    v.aluop = bi.ALUOp;       v.aow  = bi.ALUOutWrite; v.lw  = bi.LinkWrite;
    return v;
  endfunction

  // Reference model: the whole cycle-by-cycle response of one instruction.
  task automatic push_model(input logic [5:0] op, input logic z, input logic g);
    rec_t r;
    bit   is_br, is_jmp;
    is_br  = (op >= 6'h04 && op <= 6'h07);
    is_jmp = (op == 6'h02 || op == 6'h03);
    if (is_br) begin
      r = '0; r.v.busy = 1; r.v.srcb = 2'd3; r.v.aow = 1;
      q.push_back(r);
      r = '0; r.v.busy = 1; r.v.srca = 1; r.v.srcb = 2'd2; r.v.aluop = 2'd1;
      r.v.pcwc = 1; r.v.pcsrc = 2'd1; r.chk = 1;
      case (op)
        6'h04: begin r.v.ceq = 1; r.taken = z; end
        6'h05: begin r.v.ceq = 1; r.v.eqne = 1; r.taken = !z; end
        6'h07: begin r.v.cgt = 1; r.taken = g; end
        default: begin r.v.ceq = 1; r.v.cgt = 1; r.v.gtlt = 1; r.taken = z | !g; end
      endcase
      q.push_back(r);
    end
    if (op == 6'h03) begin
      r = '0; r.v.busy = 1; r.v.lw = 1;
      q.push_back(r);
    end
    if (is_jmp) begin
      r = '0; r.v.busy = 1; r.v.pcw = 1; r.v.pcsrc = 2'd2;
      q.push_back(r);
    end
    r = '0; r.v.done = 1; r.v.err = !(is_br || is_jmp);
    q.push_back(r);
  endtask

  // Monitor: compare every DUT output cycle against the scoreboard head.
  always @(negedge clk) begin
    ovec_t a;
    rec_t  r;
    logic  pw;
    if (mon_en) begin
      a = dut_vec();
      if (a.busy || a.done) begin
        check("pcw_exclusive", 32'(a.pcw & a.pcwc), 32'd0);
        if (q.size() == 0) begin
          check("unexpected_output", 32'(a), 32'd0);
        end else begin
          r  = q.pop_front();
          check("outputs", 32'(a), 32'(r.v));
          pw = a.pcw | (a.pcwc & ((a.ceq & (bi.Zero ^ a.eqne)) | (a.cgt & (bi.Gt ^ a.gtlt))));
          check("pc_write", 32'(pw), 32'(r.chk ? r.taken : r.v.pcw));
        end
      end else begin
        check("idle_outputs", 32'(a), 32'd0);
      end
    end
  end

  task automatic run_txn(input logic [5:0] op, input logic z, input logic g, input bit extra);
    int n;
    bi.Zero = z;
    bi.Gt   = g;
    push_model(op, z, g);
    bi.start  = 1'b1;
    bi.opcode = op;
    @(posedge clk); #1;
    if (extra) begin
      bi.opcode = 6'($urandom_range(2, 7));
      @(posedge clk); #1;
    end
    bi.start  = 1'b0;
    bi.opcode = 6'($urandom);
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("txn_timeout", 32'(q.size()), 32'd0);
    q.delete();
  endtask

  task automatic run_abort();
    push_model(6'h05, 1'b1, 1'b0);
    bi.Zero   = 1'b1;
    bi.Gt     = 1'b0;
    bi.start  = 1'b1;
    bi.opcode = 6'h05;
    @(posedge clk); #1;
    bi.start  = 1'b0;
    @(posedge clk); #1;
    check("abort_in_compare", 32'(bi.PCWriteCond), 32'd1);
    reset_n = 1'b0;
    #1;
    check("abort_outputs", 32'(dut_vec()), 32'd0);
    q.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 check("abort_idle", 32'({bi.busy, bi.done}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int gap;
    logic [5:0] op;
    bi.start  = 1'b1;
    bi.opcode = 6'h04;
    bi.Zero   = 1'b0;
    bi.Gt     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'(dut_vec()), 32'd0);
    check("reset_no_done", 32'(bi.done), 32'd0);
    bi.start = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    mon_en  = 1'b1;
    @(posedge clk); #1;

    run_txn(6'h04, 1'b1, 1'b0, 1'b0);
    run_txn(6'h06, 1'b0, 1'b0, 1'b0);
    run_txn(6'h03, 1'b0, 1'b1, 1'b0);
    run_txn(6'h23, 1'b0, 1'b0, 1'b1);
    run_txn(6'h02, 1'b1, 1'b1, 1'b1);
    run_txn(6'h07, 1'b0, 1'b1, 1'b1);
    run_txn(6'h05, 1'b1, 1'b0, 1'b0);
    run_abort();
    run_txn(6'h06, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) op = 6'($urandom_range(0, 63));
      else op = 6'($urandom_range(2, 7));
      run_txn(op, 1'($urandom), 1'($urandom), 1'($urandom_range(0, 2) == 0));
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk); #1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    check("final_queue", 32'(q.size()), 32'd0);
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
